// File: rtl/spi_flash_read_seq.sv
// spi_flash_read_seq: turns one read request into an SPI flash 0x03 read
// driven through spi_controller_iomem, streaming the data bytes back to the
// requester over a valid/ready byte interface.
module spi_flash_read_seq #(
    parameter logic [7:0]  CMD_READ = 8'h03,
    parameter int unsigned POLL_GAP = 2,
    parameter int unsigned LEN_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_req,
    input  logic [23:0]      i_req_addr,
    input  logic [LEN_W-1:0] i_req_len,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    output logic [7:0]       o_rx_data,
    output logic             o_rx_valid,
    input  logic             i_rx_ready,
    output logic             o_ctl_sel,
    output logic [7:0]       o_ctl_addr,
    output logic [3:0]       o_ctl_wstrb,
    output logic [31:0]      o_ctl_wdata,
    input  logic [31:0]      i_ctl_rdata
);
    // Two extra bits cover the 4 header bytes on top of the maximum length.
    localparam int unsigned IDX_W = LEN_W + 2;

    typedef enum logic [2:0] {StIdle, StSend, StPoll, StGap, StEmit, StDone} state_t;

    state_t             r_state;
    logic [1:0]         r_phase;      // POLL: 0 gap, 1 strobe on bus, 2 rdata valid
    logic [3:0]         r_gap_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [23:0]        r_addr;
    logic [LEN_W-1:0]   r_len;
    logic               r_abort_pend;
    logic               r_release;    // CS-release byte has been sent
    logic               r_busy;
    logic               r_done;
    logic [7:0]         r_rx_data;
    logic               r_rx_valid;
    logic               r_ctl_sel;
    logic [3:0]         r_ctl_wstrb;
    logic [31:0]        r_ctl_wdata;

    logic [IDX_W-1:0]   w_last_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [7:0]         w_tx_byte;
    logic               w_tx_hold;
    logic               w_abort;
    logic               w_ctl_busy;
    logic               w_unused;

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_rx_data   = r_rx_data;
    assign o_rx_valid  = r_rx_valid;
    assign o_ctl_sel   = r_ctl_sel;
    assign o_ctl_addr  = 8'h00;
    assign o_ctl_wstrb = r_ctl_wstrb;
    assign o_ctl_wdata = r_ctl_wdata;
    assign w_unused    = ^i_ctl_rdata[30:8];

    // Byte and hold flag for the next SPI byte (index r_idx + 1).
    always_comb begin
        w_last_idx = {2'b00, r_len} + IDX_W'(3);
        w_idx_nxt  = r_idx + IDX_W'(1);
        if (w_idx_nxt == IDX_W'(1)) begin
            w_tx_byte = r_addr[23:16];
        end else if (w_idx_nxt == IDX_W'(2)) begin
            w_tx_byte = r_addr[15:8];
        end else if (w_idx_nxt == IDX_W'(3)) begin
            w_tx_byte = r_addr[7:0];
        end else begin
            w_tx_byte = 8'h00;
        end
        w_tx_hold  = (w_idx_nxt != w_last_idx);
        w_abort    = r_abort_pend | i_abort;
        w_ctl_busy = i_ctl_rdata[31];
    end

    // Sequencer FSM; all outputs registered, ctl_sel is a one-cycle strobe.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= StIdle;
            r_phase      <= 2'd0;
            r_gap_cnt    <= 4'd0;
            r_idx        <= '0;
            r_addr       <= 24'h0;
            r_len        <= '0;
            r_abort_pend <= 1'b0;
            r_release    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_ctl_sel    <= 1'b0;
            r_ctl_wstrb  <= 4'h0;
            r_ctl_wdata  <= 32'h0;
        end else begin
            r_ctl_sel <= 1'b0;
            r_done    <= 1'b0;
            if (i_abort && r_state != StIdle && r_state != StDone) begin
                r_abort_pend <= 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    if (i_req) begin
                        if (i_req_len != '0) begin
                            r_addr      <= i_req_addr;
                            r_len       <= i_req_len;
                            r_idx       <= '0;
                            r_busy      <= 1'b1;
                            r_release   <= 1'b0;
                            r_ctl_sel   <= 1'b1;
                            r_ctl_wstrb <= 4'hF;
                            r_ctl_wdata <= {16'h0, 8'h01, CMD_READ};
                            r_state     <= StSend;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end
                    end
                end
                StSend: begin
                    r_phase <= 2'd0;
                    r_state <= StPoll;
                end
                StPoll: begin
                    case (r_phase)
                        2'd0: begin
                            r_ctl_sel   <= 1'b1;
                            r_ctl_wstrb <= 4'h0;
                            r_ctl_wdata <= 32'h0;
                            r_phase     <= 2'd1;
                        end
                        2'd1: r_phase <= 2'd2;
                        default: begin
                            if (w_ctl_busy) begin
                                if (POLL_GAP == 0) begin
                                    r_ctl_sel   <= 1'b1;
                                    r_ctl_wstrb <= 4'h0;
                                    r_ctl_wdata <= 32'h0;
                                    r_phase     <= 2'd1;
                                end else begin
                                    r_gap_cnt <= 4'(POLL_GAP - 1);
                                    r_state   <= StGap;
                                end
                            end else if (r_release) begin
                                r_done       <= 1'b1;
                                r_busy       <= 1'b0;
                                r_abort_pend <= 1'b0;
                                r_release    <= 1'b0;
                                r_state      <= StDone;
                            end else if (w_abort) begin
                                // Zero byte without hold makes the controller drop CS.
                                r_release   <= 1'b1;
                                r_ctl_sel   <= 1'b1;
                                r_ctl_wstrb <= 4'hF;
                                r_ctl_wdata <= 32'h0;
                                r_state     <= StSend;
                            end else if (r_idx < IDX_W'(4)) begin
                                r_idx       <= w_idx_nxt;
                                r_ctl_sel   <= 1'b1;
                                r_ctl_wstrb <= 4'hF;
                                r_ctl_wdata <= {16'h0, 7'h0, w_tx_hold, w_tx_byte};
                                r_state     <= StSend;
                            end else begin
                                r_rx_data  <= i_ctl_rdata[7:0];
                                r_rx_valid <= 1'b1;
                                r_state    <= StEmit;
                            end
                        end
                    endcase
                end
                StGap: begin
                    if (r_gap_cnt == 4'd0) begin
                        r_ctl_sel   <= 1'b1;
                        r_ctl_wstrb <= 4'h0;
                        r_ctl_wdata <= 32'h0;
                        r_phase     <= 2'd1;
                        r_state     <= StPoll;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                StEmit: begin
                    if (w_abort) begin
                        // Pending byte is discarded; controller is idle here.
                        r_rx_valid  <= 1'b0;
                        r_release   <= 1'b1;
                        r_ctl_sel   <= 1'b1;
                        r_ctl_wstrb <= 4'hF;
                        r_ctl_wdata <= 32'h0;
                        r_state     <= StSend;
                    end else if (i_rx_ready) begin
                        r_rx_valid <= 1'b0;
                        if (r_idx == w_last_idx) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= StDone;
                        end else begin
                            r_idx       <= w_idx_nxt;
                            r_ctl_sel   <= 1'b1;
                            r_ctl_wstrb <= 4'hF;
                            r_ctl_wdata <= {16'h0, 7'h0, w_tx_hold, w_tx_byte};
                            r_state     <= StSend;
                        end
                    end
                end
                StDone: r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
